fetch_ctrl: RTL and testbench

- Top-level program sequencer for the single-cycle core; owns the InstFetch program counter's run/stall/halt lifecycle.
- On Start it loads the selected program's entry address, lets the PC advance each cycle, freezes it while data memory is busy, and ends the run on a halt instruction or a watchdog expiry.
- Sits between the testbench start/done handshake, the decoder (Halt) and data memory (MemBusy).

---
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Program sequencer for the single-cycle core: start/load/run/stall/done lifecycle of the fetch PC.
// Optional watchdog compiled in with `define FETCH_WATCHDOG_EN (ends a run after MAX_CYCLES counted cycles).
`timescale 1ns/1ps
module fetch_ctrl #(
  parameter int T          = 10,
  parameter int CW         = 16,
  parameter int PROG0_ADDR = 0,
  parameter int PROG1_ADDR = 256,
  parameter int PROG2_ADDR = 512,
  parameter int PROG3_ADDR = 768,
  parameter int MAX_CYCLES = 'hFFF0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic          Halt,
  input  logic          MemBusy,
  output logic          PcLoad,
  output logic [T-1:0]  PcLoadVal,
  output logic          PcEn,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

`ifdef FETCH_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t          state_q, state_d;
  logic [T-1:0]    pc_val_q, pc_val_d;
  logic [CW-1:0]   count_q, count_d;
  logic            timeout_q, timeout_d;
  logic            busy_w;
  logic            wd_hit;

  function automatic logic [T-1:0] entry_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    return T'(PROG0_ADDR);
      2'd1:    return T'(PROG1_ADDR);
      2'd2:    return T'(PROG2_ADDR);
      default: return T'(PROG3_ADDR);
    endcase
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      pc_val_q  <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_val_q  <= pc_val_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_w = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_STALL);
  // Watchdog compares the pre-increment count, so the run ends with exactly MAX_CYCLES counted.
  assign wd_hit = WD_EN && busy_w && (count_q == WD_LAST);

  always_comb begin
    state_d   = state_q;
    pc_val_d  = pc_val_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    PcLoad    = 1'b0;
    PcEn      = 1'b0;

    if (busy_w && (count_q != CNT_MAX)) begin
      count_d = count_q + CW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d   = S_LOAD;
          pc_val_d  = entry_addr(ProgSel);
          count_d   = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: begin
        PcLoad = 1'b1;
        if (wd_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        PcEn = !MemBusy && !Halt;
        if (Halt) begin
          state_d = S_DONE;
        end else if (wd_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (MemBusy) begin
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        // Halt is deliberately ignored here; the PC is frozen on a stale instruction.
        if (wd_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (!MemBusy) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PcLoadVal  = pc_val_q;
  assign Busy       = busy_w;
  assign Done       = (state_q == S_DONE);
  assign Timeout    = timeout_q;
  assign CycleCount = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic against a run-level model.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  localparam int T    = 10;
  localparam int CW   = 16;
  localparam int MAXC = 20;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FETCH_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [1:0]    ProgSel = 2'd0;
  logic          Halt = 1'b0;
  logic          MemBusy = 1'b0;
  logic          PcLoad;
  logic [T-1:0]  PcLoadVal;
  logic          PcEn;
  logic          Busy;
  logic          Done;
  logic          Timeout;
  logic [CW-1:0] CycleCount;

  fetch_ctrl #(.T(T), .CW(CW), .MAX_CYCLES(MAXC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .MemBusy(MemBusy), .PcLoad(PcLoad), .PcLoadVal(PcLoadVal), .PcEn(PcEn),
    .Busy(Busy), .Done(Done), .Timeout(Timeout), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int addr_tab [4] = '{0, 256, 512, 768};

  // Run-level model: a run is "first cycle" (PC load), then "executing" or "frozen" until it finishes.
  bit m_first, m_exec, m_frozen, m_finished, m_to;
  int m_count, m_pcval;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_first = 0; m_exec = 0; m_frozen = 0; m_finished = 0; m_to = 0;
    m_count = 0; m_pcval = 0;
  endtask

  task automatic model_edge(input bit st, input logic [1:0] sel, input bit h, input bit mb);
    bit in_run, wd, by_halt;
    if (!Reset) return;
    in_run  = m_first || m_exec || m_frozen;
    wd      = WD_ON && in_run && (m_count == MAXC - 1);
    by_halt = m_exec && h;
    if (in_run) m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
    if (!in_run) begin
      if (st) begin
        m_first = 1; m_finished = 0; m_to = 0; m_count = 0;
        m_pcval = addr_tab[sel];
      end
    end else if (by_halt || wd) begin
      m_first = 0; m_exec = 0; m_frozen = 0; m_finished = 1;
      m_to = !by_halt;
    end else if (m_first) begin
      m_first = 0; m_exec = 1;
    end else if (m_exec && mb) begin
      m_exec = 0; m_frozen = 1;
    end else if (m_frozen && !mb) begin
      m_frozen = 0; m_exec = 1;
    end
  endtask

  task automatic cmp_model();
    chk("PcLoad", PcLoad, m_first);
    chk("PcLoadVal", PcLoadVal, m_pcval);
    chk("PcEn", PcEn, m_exec && !MemBusy && !Halt);
    chk("Busy", Busy, m_first || m_exec || m_frozen);
    chk("Done", Done, m_finished);
    chk("Timeout", Timeout, m_to);
    chk("CycleCount", CycleCount, m_count);
  endtask

  // One clock: drive inputs, compare on the falling edge, advance the model on the rising edge.
  task automatic cycle(input bit st, input logic [1:0] sel, input bit h, input bit mb);
    Start = st; ProgSel = sel; Halt = h; MemBusy = mb;
    @(negedge Clk);
    cmp_model();
    @(posedge Clk);
    model_edge(st, sel, h, mb);
    #1;
  endtask

  initial begin
    model_reset();
    // Reset for 3 cycles, then 5 idle cycles.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    chk("idle_busy", Busy, 0);
    chk("idle_done", Done, 0);
    chk("idle_count", CycleCount, 0);

    // Program 2, ten RUN cycles, halt on the tenth.
    cycle(1, 2, 0, 0);
    chk("load_pcload", PcLoad, 1);
    chk("load_val", PcLoadVal, 512);
    cycle(0, 0, 0, 0);
    Start = 0; Halt = 0; MemBusy = 0; #1;
    chk("run_pcen", PcEn, 1);
    chk("run_busy", Busy, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("halt_done", Done, 1);
    chk("halt_count", CycleCount, 11);
    chk("halt_timeout", Timeout, 0);

    // Three-cycle memory stall plus one bubble, then a Start ignored during RUN.
    cycle(1, 2, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("stall_count", CycleCount, 5);
    cycle(1, 1, 0, 0);
    chk("ign_pcload", PcLoad, 0);
    chk("ign_val", PcLoadVal, 512);
    chk("ign_count", CycleCount, 6);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    chk("stall_halt_done", Done, 0);
    chk("stall_halt_busy", Busy, 1);
    cycle(0, 0, 0, 0);
    Halt = 1; MemBusy = 1; #1;
    chk("halt_mb_pcen", PcEn, 0);
    cycle(0, 0, 1, 1);
    chk("halt_mb_done", Done, 1);
    chk("halt_mb_count", CycleCount, 10);

    // Start with Halt in DONE: Start wins; program 3.
    cycle(1, 3, 1, 0);
    chk("p3_val", PcLoadVal, 768);
    chk("p3_count", CycleCount, 0);
    chk("p3_pcload", PcLoad, 1);
    cycle(0, 0, 0, 0);

    // Asynchronous reset mid-RUN.
    Start = 0; Halt = 0; MemBusy = 0; #2;
    chk("pre_rst_pcen", PcEn, 1);
    Reset = 1'b0; #1;
    chk("async_busy", Busy, 0);
    chk("async_pcen", PcEn, 0);
    chk("async_val", PcLoadVal, 0);
    model_reset();
    @(posedge Clk); #1;
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
    Reset = 1'b1;
    cycle(0, 0, 0, 0);

    // Never halt: watchdog ends the run, or the count saturates without it.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < (WD_ON ? 30 : 65540); i++) cycle(0, 0, 0, 0);
`ifdef FETCH_WATCHDOG_EN
    chk("wd_done", Done, 1);
    chk("wd_timeout", Timeout, 1);
    chk("wd_count", CycleCount, 20);
`else
    chk("sat_busy", Busy, 1);
    chk("sat_count", CycleCount, 65535);
    chk("sat_timeout", Timeout, 0);
`endif

    // Random traffic against the model.
    Reset = 1'b0; model_reset();
    cycle(0, 0, 0, 0);
    Reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
